// File: rtl/mcu_spi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mcu_spi
// Brief  : Oversampled SPI slave (mode 0) that routes MCU bytes to one of four
//          on-chip targets chosen by the first byte of each frame.
// Rev    : 1.0  initial release
// ============================================================================
module mcu_spi #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TGT_SYS     = 8'd1,
    parameter logic [7:0] TGT_HID     = 8'd2,
    parameter logic [7:0] TGT_OSD     = 8'd3,
    parameter logic [7:0] TGT_SDC     = 8'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_io_ss,
    input  logic       spi_io_clk,
    input  logic       spi_io_din,
    output logic       spi_io_dout,
    output logic       mcu_sys_strobe,
    output logic       mcu_hid_strobe,
    output logic       mcu_osd_strobe,
    output logic       mcu_sdc_strobe,
    output logic       mcu_start,
    output logic [7:0] mcu_dout,
    input  logic [7:0] mcu_sys_din,
    input  logic [7:0] mcu_hid_din,
    input  logic [7:0] mcu_osd_din,
    input  logic [7:0] mcu_sdc_din
);

    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_ss_d;
    logic                   r_sck_d;
    logic [SYNC_STAGES:0]   r_flush;
    logic                   r_armed;

    logic       w_ss;
    logic       w_sck;
    logic       w_din;
    logic       w_ss_fall;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_idle;

    logic [2:0] r_bit_cnt;
    logic [1:0] r_byte_idx;
    logic [7:0] r_target;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [3:0] r_strobe;
    logic       r_start;
    logic [7:0] r_dout;

    logic [7:0] w_rx_byte;
    logic [3:0] w_hit;
    logic [7:0] w_sel_din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ss_sync  <= '1;
            r_sck_sync <= '0;
            r_din_sync <= '0;
            r_ss_d     <= 1'b1;
            r_sck_d    <= 1'b0;
            r_flush    <= '0;
        end else begin
            r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0],  spi_io_ss};
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_io_clk};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], spi_io_din};
            r_ss_d     <= r_ss_sync[SYNC_STAGES-1];
            r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
            r_flush    <= {r_flush[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_din      = r_din_sync[SYNC_STAGES-1];
    assign w_ss_fall  = r_ss_d & ~w_ss;
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;

    // The synchroniser presets ss high, so a chip select still held low across
    // reset would look like a fresh fall. Arm only once real ss is seen high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (r_flush[SYNC_STAGES] && w_ss) begin
            r_armed <= 1'b1;
        end
    end

    assign w_idle    = w_ss | w_ss_fall | ~r_armed;
    assign w_rx_byte = {r_rx_shift, w_din};

    always_comb begin
        w_hit     = 4'b0000;
        w_sel_din = 8'h00;
        if (r_target == TGT_SYS) begin
            w_hit     = 4'b0001;
            w_sel_din = mcu_sys_din;
        end else if (r_target == TGT_HID) begin
            w_hit     = 4'b0010;
            w_sel_din = mcu_hid_din;
        end else if (r_target == TGT_OSD) begin
            w_hit     = 4'b0100;
            w_sel_din = mcu_osd_din;
        end else if (r_target == TGT_SDC) begin
            w_hit     = 4'b1000;
            w_sel_din = mcu_sdc_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_target   <= 8'h00;
            r_rx_shift <= 7'h00;
            r_tx_shift <= 8'h00;
            r_strobe   <= 4'b0000;
            r_start    <= 1'b0;
            r_dout     <= 8'h00;
        end else begin
            r_strobe <= 4'b0000;
            r_start  <= 1'b0;
            if (w_idle) begin
                r_bit_cnt  <= 3'd0;
                r_byte_idx <= 2'd0;
                r_tx_shift <= 8'h00;
                r_target   <= 8'h00;
            end else begin
                if (w_sck_rise) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (r_byte_idx == 2'd0) begin
                            r_target   <= w_rx_byte;
                            r_byte_idx <= 2'd1;
                        end else begin
                            r_dout     <= w_rx_byte;
                            r_strobe   <= w_hit;
                            r_start    <= (r_byte_idx == 2'd1) && (w_hit != 4'b0000);
                            r_byte_idx <= 2'd2;
                        end
                    end
                end
                // MISO is the MSB of the shifter; reload at each byte boundary.
                if (w_sck_fall) begin
                    if (r_bit_cnt != 3'd0) begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end else if (r_byte_idx != 2'd0) begin
                        r_tx_shift <= w_sel_din;
                    end
                end
            end
        end
    end

    assign spi_io_dout    = r_tx_shift[7];
    assign mcu_sys_strobe = r_strobe[0];
    assign mcu_hid_strobe = r_strobe[1];
    assign mcu_osd_strobe = r_strobe[2];
    assign mcu_sdc_strobe = r_strobe[3];
    assign mcu_start      = r_start;
    assign mcu_dout       = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_mcu_spi
// Brief  : Directed and randomized frames for mcu_spi against a frame-level
//          model of strobes, start flags, latency and delayed MISO responses.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mcu_spi;

    localparam int SYNC = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       ss    = 1'b1;
    logic       sck   = 1'b0;
    logic       mosi  = 1'b0;
    logic       miso;
    logic       sys_stb, hid_stb, osd_stb, sdc_stb, start;
    logic [7:0] dout;
    logic [7:0] resp [4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         tgt;
        logic [7:0] data;
        logic       start;
        int         cyc;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] frm[$];
    logic [7:0] miso_got[$];

    mcu_spi #(
        .SYNC_STAGES(SYNC),
        .TGT_SYS    (8'd1),
        .TGT_HID    (8'd2),
        .TGT_OSD    (8'd3),
        .TGT_SDC    (8'd4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_io_ss     (ss),
        .spi_io_clk    (sck),
        .spi_io_din    (mosi),
        .spi_io_dout   (miso),
        .mcu_sys_strobe(sys_stb),
        .mcu_hid_strobe(hid_stb),
        .mcu_osd_strobe(osd_stb),
        .mcu_sdc_strobe(sdc_stb),
        .mcu_start     (start),
        .mcu_dout      (dout),
        .mcu_sys_din   (resp[0]),
        .mcu_hid_din   (resp[1]),
        .mcu_osd_din   (resp[2]),
        .mcu_sdc_din   (resp[3])
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Strobe monitor plus target responders: each strobe makes the target
    // present a new response byte for the MCU to read during the next byte.
    initial forever begin
        logic [3:0] s;
        int         idx;
        @(negedge clk);
        s = {sdc_stb, osd_stb, hid_stb, sys_stb};
        n_tests++;
        assert ($onehot0(s) && !(start === 1'b1 && s == 4'b0000))
        else begin
            n_fail++;
            $error("FAIL strobe_onehot: observed strobes=%b start=%b, required at most one strobe and start only with a strobe", s, start);
        end
        if (s != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (s[i]) idx = i;
            obs_q.push_back('{idx, dout, start, cyc});
            if (resp_q.size() > 0) resp[idx] = resp_q.pop_front();
            else                   resp[idx] = 8'($urandom);
        end
    end

    function automatic int tgt_index(input logic [7:0] code);
        case (code)
            8'd1:    return 0;
            8'd2:    return 1;
            8'd3:    return 2;
            8'd4:    return 3;
            default: return -1;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SCK at clk/8: data set with the falling edge, MISO sampled just before rise.
    task automatic spi_byte(input logic [7:0] v, input int nb, input bit raise_ss,
                            output logic [7:0] rx, output int rise_cyc);
        rx       = 8'h00;
        rise_cyc = 0;
        for (int b = 0; b < nb; b++) begin
            mosi = v[7-b];
            tick(4);
            rx[7-b] = miso;
            sck     = 1'b1;
            if (b == 7) begin
                rise_cyc = cyc;
                if (raise_ss) ss = 1'b1;
            end
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int gap, input int cut_bits, input bit coincide);
        int         n;
        int         ti;
        int         nb;
        int         rc;
        bit         last;
        logic [7:0] em;
        logic [7:0] rx;
        n  = frm.size();
        ti = tgt_index(frm[0]);
        obs_q.delete();
        exp_q.delete();
        miso_got.delete();
        ss = 1'b0;
        tick(4);
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            nb   = (last && cut_bits >= 0) ? cut_bits : 8;
            em   = (k >= 1 && ti >= 0) ? resp[ti] : 8'h00;
            spi_byte(frm[k], nb, last && coincide, rx, rc);
            if (nb == 8) begin
                miso_got.push_back(rx);
                check($sformatf("miso_byte%0d", k), rx, em);
            end
            if (nb == 8 && k >= 1 && ti >= 0 && !(last && coincide))
                exp_q.push_back('{ti, frm[k], (k == 1), rc + SYNC + 1});
        end
        tick(4);
        ss = 1'b1;
        tick(gap);
        check("strobe_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("ev%0d_target", i), obs_q[i].tgt,   exp_q[i].tgt);
            check($sformatf("ev%0d_data", i),   obs_q[i].data,  exp_q[i].data);
            check($sformatf("ev%0d_start", i),  obs_q[i].start, exp_q[i].start);
            check($sformatf("ev%0d_cycle", i),  obs_q[i].cyc,   exp_q[i].cyc);
        end
    endtask

    task automatic random_frame(input bit known_only);
        int sel;
        int len;
        sel = known_only ? $urandom_range(0, 3) : $urandom_range(0, 4);
        frm.delete();
        frm.push_back(sel < 4 ? 8'(sel + 1) : 8'($urandom_range(5, 255)));
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) frm.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] rx;
        int         rc;
        for (int i = 0; i < 4; i++) resp[i] = 8'h00;

        tick(3);
        check("rst_strobes", {sdc_stb, osd_stb, hid_stb, sys_stb}, 4'b0000);
        check("rst_start",   start, 1'b0);
        check("rst_dout",    dout,  8'h00);
        check("rst_miso",    miso,  1'b0);
        reset = 1'b0;
        tick(4);

        resp_q = '{8'h5C, 8'h42, 8'h00};
        frm    = '{8'h01, 8'h00, 8'h00, 8'h00};
        run_frame(6, -1, 1'b0);
        check("sys_miso_b2", miso_got[2], 8'h5C);
        check("sys_miso_b3", miso_got[3], 8'h42);
        check("sys_dout",    dout,        8'h00);

        frm = '{8'h03, 8'hAA, 8'h55};
        run_frame(6, -1, 1'b0);
        check("osd_dout", dout, 8'h55);

        frm = '{8'h09, 8'h12, 8'h34, 8'h56};
        run_frame(6, -1, 1'b0);

        obs_q.delete();
        spi_byte(8'h01, 8, 1'b0, rx, rc);
        spi_byte(8'h99, 8, 1'b0, rx, rc);
        tick(8);
        check("spurious_sck_strobes", obs_q.size(), 0);

        frm = '{8'h02, 8'h5A};
        run_frame(6, 5, 1'b0);
        frm = '{8'h02, 8'h7E};
        run_frame(6, -1, 1'b0);
        check("hid_dout", dout, 8'h7E);

        frm = '{8'h03, 8'h12, 8'h34};
        run_frame(6, -1, 1'b1);

        ss = 1'b0;
        tick(4);
        spi_byte(8'h04, 8, 1'b0, rx, rc);
        spi_byte(8'h11, 4, 1'b0, rx, rc);
        reset = 1'b1;
        tick(2);
        check("midrst_strobes", {sdc_stb, osd_stb, hid_stb, sys_stb}, 4'b0000);
        check("midrst_start",   start, 1'b0);
        check("midrst_dout",    dout,  8'h00);
        check("midrst_miso",    miso,  1'b0);
        reset = 1'b0;
        obs_q.delete();
        spi_byte(8'h04, 8, 1'b0, rx, rc);
        spi_byte(8'h11, 8, 1'b0, rx, rc);
        tick(8);
        check("post_rst_no_fall", obs_q.size(), 0);
        ss = 1'b1;
        tick(6);
        frm = '{8'h04, 8'h11};
        run_frame(6, -1, 1'b0);
        check("sdc_dout", dout, 8'h11);

        for (int f = 0; f < 3; f++) begin
            random_frame(1'b1);
            run_frame(2, -1, 1'b0);
        end

        for (int r = 0; r < 12; r++) begin
            random_frame(1'b0);
            run_frame($urandom_range(2, 10), -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
